alu_ctrl_fsm: RTL and testbench
===============================

# alu_ctrl_fsm

Multi-cycle control sequencer that drives the `ALUctrl` / operand-select side of the CPU's 32-bit ALU and consumes its zero flag. It accepts one RV32I-subset instruction word per handshake, decodes it, and holds a stable ALU function code for the execute cycle. It then issues a register-write strobe or a branch decision, and returns to idle. It sits between the instruction register and the datapath (regfile, ALU, PC mux).

## Interface

- `DATA_WIDTH`, default 32: instruction word width. Only 32 is supported.
- `clk` input, 1 bit: rising-edge clock.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `instr_i` input, `DATA_WIDTH` bits: instruction word. Sampled only on an accept.
- `instr_valid_i` input, 1 bit: `instr_i` is valid.
- `instr_ready_o` output, 1 bit: block can accept. High only in IDLE.
- `zero_i` input, 1 bit: ALU zero flag (1 when the ALU result is 0).
- `alu_ctrl_o` output, 3 bits: ALU function code. ADD=0, SUB=1, AND=2, OR=3, SLT=4, LSHIFT=5, PASSOP2=6.
- `alu_src_o` output, 1 bit: 1 selects the immediate as ALU op2; 0 selects rs2.
- `reg_write_o` output, 1 bit: one-cycle regfile write strobe.
- `pc_src_o` output, 1 bit: one-cycle branch-taken strobe.
- `illegal_o` output, 1 bit: one-cycle strobe for an unsupported encoding.
- `done_o` output, 1 bit: one-cycle strobe marking the last cycle of every instruction, including illegal ones.

## Operation

- States are IDLE, DECODE, EXEC, WB, BR and ERR. Reset enters IDLE.
- IDLE: `instr_ready_o`=1. When `instr_valid_i` and `instr_ready_o` are both high on a clock edge, `instr_i` is latched into an internal register and the FSM moves to DECODE.
- DECODE: the latched opcode, funct3 and funct7[5] are decoded into registered fields: function code, `alu_src`, class (R/I/LUI/BR) and branch kind.
  - The next state is EXEC, or ERR if the encoding is unsupported.
- Supported R-type encodings (opcode 0110011, `alu_src`=0):
  - funct3 000 is add (ADD) when funct7[5]=0, or sub (SUB) when funct7[5]=1.
  - funct3 001 is sll (LSHIFT).
  - funct3 010 is slt (SLT).
  - funct3 110 is or (OR).
  - funct3 111 is and (AND).
- Supported I-type encodings (opcode 0010011, `alu_src`=1): addi, slli, slti, ori, andi, using the same funct3 mapping as R-type.
  - slli requires funct7=0000000.
- LUI (opcode 0110111): PASSOP2, `alu_src`=1.
- Branches (opcode 1100011): SUB, `alu_src`=0.
  - beq (funct3 000) is taken when `zero_i`=1.
  - bne (funct3 001) is taken when `zero_i`=0.
- Every other encoding is illegal, including R-type funct3 000 with any funct7 other than 0000000 or 0100000.
- EXEC: `alu_ctrl_o` and `alu_src_o` are driven from the decoded fields. The next state is BR for branches, otherwise WB.
- WB: `alu_ctrl_o` and `alu_src_o` are held. `reg_write_o`=1 and `done_o`=1. The next state is IDLE.
- BR: `alu_ctrl_o` and `alu_src_o` are held. `pc_src_o` is the taken condition evaluated on the current `zero_i`. `reg_write_o`=0, `done_o`=1. The next state is IDLE.
- ERR: `illegal_o`=1 and `done_o`=1. No write and no branch. The next state is IDLE.
- Outputs are a function of the current state and the registered decode fields only. `instr_i` never affects outputs combinationally.
- In IDLE and DECODE, `alu_ctrl_o`=0 (ADD) and `alu_src_o`=0.

## Timing

- Reset values: state IDLE, `instr_ready_o`=1, `alu_ctrl_o`=0, and `alu_src_o`, `reg_write_o`, `pc_src_o`, `illegal_o`, `done_o` all 0. The latched instruction is 0.
- Reset applies immediately when asserted, mid-instruction included. The in-flight instruction is dropped, and no strobe is emitted after reset is asserted.
- If the accept happens at edge T, the block is in DECODE in cycle T+1, EXEC in T+2, and WB, BR or ERR in T+3.
  - For ERR the sequence is DECODE at T+1 then ERR at T+2.
  - `instr_ready_o` is high again in cycle T+4 (T+3 for illegal encodings).
- Throughput is one instruction per 4 cycles.
- `instr_valid_i` held high while ready is low has no effect. The word is not consumed until the next IDLE edge.
- `alu_ctrl_o` and `alu_src_o` are stable from EXEC through WB/BR, so the ALU has two full cycles to settle before `zero_i` is used.

## Configuration

- `ALU_CTRL_BNE_EN` defined: bne (branch funct3 001) is supported, taken when `zero_i`=0.
- `ALU_CTRL_BNE_EN` undefined: branch funct3 001 decodes as illegal and follows the ERR path.
- beq is unaffected either way.

## Test plan

- Reset, then accept 0x002081B3 (add x3,x1,x2):
  - T+2: `alu_ctrl_o`=0, `alu_src_o`=0.
  - T+3: `reg_write_o`=1, `done_o`=1.
  - T+4: `instr_ready_o`=1.
- Accept 0x402081B3 (sub), then 0x0050E193 (ori): `alu_ctrl_o` is 1 in EXEC/WB of the first, and 3 with `alu_src_o`=1 for the second.
- Accept 0x00208463 (beq):
  - With `zero_i`=1 in cycle T+3, `pc_src_o`=1 and `reg_write_o`=0.
  - Repeat with `zero_i`=0: `pc_src_o`=0.
- Accept 0x00209463 (bne) with `zero_i`=0:
  - With `ALU_CTRL_BNE_EN` defined, `pc_src_o`=1 at T+3.
  - Without the macro, `illegal_o`=1 at T+2 and no `pc_src_o`.
- Accept 0x123452B7 (lui): `alu_ctrl_o`=6 and `alu_src_o`=1 in EXEC, then `reg_write_o`=1. Accept 0x00000000: `illegal_o`=`done_o`=1 at T+2, with no write.
- Assert `rst` during EXEC of an add, and hold `instr_valid_i` high while busy:
  - After the reset edge, every output equals its reset value, and `reg_write_o` never pulses.
  - The held word is accepted only at the next IDLE edge.

Source files
------------

// File: rtl/alu_ctrl_fsm.sv
// alu_ctrl_fsm
// Multi-cycle control sequencer for the 32-bit ALU datapath. Accepts one
// RV32I-subset instruction per handshake, decodes it into a registered ALU
// function code / operand select, then emits a register-write strobe, a
// branch-taken strobe or an illegal-encoding strobe before returning to idle.
//
// Optional feature macro: ALU_CTRL_BNE_EN (when defined, bne is supported;
// otherwise branch funct3 001 takes the illegal path).
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   instr_i        instruction word, sampled only on accept
//   instr_valid_i  instr_i is valid
//   instr_ready_o  high only in IDLE
//   zero_i         ALU zero flag, used in the branch cycle
//   alu_ctrl_o     ALU function code (ADD=0 SUB=1 AND=2 OR=3 SLT=4 LSHIFT=5 PASSOP2=6)
//   alu_src_o      1 = immediate as op2, 0 = rs2
//   reg_write_o    one-cycle regfile write strobe
//   pc_src_o       one-cycle branch-taken strobe
//   illegal_o      one-cycle unsupported-encoding strobe
//   done_o         one-cycle strobe on the last cycle of every instruction
module alu_ctrl_fsm #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] instr_i,
   input  logic                  instr_valid_i,
   output logic                  instr_ready_o,
   input  logic                  zero_i,
   output logic [2:0]            alu_ctrl_o,
   output logic                  alu_src_o,
   output logic                  reg_write_o,
   output logic                  pc_src_o,
   output logic                  illegal_o,
   output logic                  done_o
);

   localparam logic [2:0] FN_ADD     = 3'd0;
   localparam logic [2:0] FN_SUB     = 3'd1;
   localparam logic [2:0] FN_AND     = 3'd2;
   localparam logic [2:0] FN_OR      = 3'd3;
   localparam logic [2:0] FN_SLT     = 3'd4;
   localparam logic [2:0] FN_LSHIFT  = 3'd5;
   localparam logic [2:0] FN_PASSOP2 = 3'd6;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_BR  = 7'b1100011;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_EXEC,
      S_WB,
      S_BR,
      S_ERR
   } state_t;

   state_t state, state_next;

   logic [DATA_WIDTH-1:0] instr_q;
   logic [2:0]            dec_ctrl_q;
   logic                  dec_src_q;
   logic                  dec_branch_q;
   logic                  dec_bne_q;

   logic [2:0] d_ctrl;
   logic       d_src;
   logic       d_branch;
   logic       d_bne;
   logic       d_illegal;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;

   assign opcode = instr_q[6:0];
   assign funct3 = instr_q[14:12];
   assign funct7 = instr_q[31:25];

   // Register/immediate fields are consumed by the datapath, not here.
   logic unused_fields;
   assign unused_fields = ^{instr_q[24:15], instr_q[11:7]};

   // Decode of the latched word; only meaningful while in DECODE.
   always_comb begin
      d_ctrl    = FN_ADD;
      d_src     = 1'b0;
      d_branch  = 1'b0;
      d_bne     = 1'b0;
      d_illegal = 1'b0;
      case (opcode)
         OP_R, OP_I: begin
            d_src = (opcode == OP_I);
            case (funct3)
               3'b000: begin
                  if (opcode == OP_R) begin
                     if (funct7 == 7'b0100000)      d_ctrl = FN_SUB;
                     else if (funct7 != 7'b0000000) d_illegal = 1'b1;
                  end
               end
               3'b001: begin
                  d_ctrl = FN_LSHIFT;
                  if (opcode == OP_I && funct7 != 7'b0000000) d_illegal = 1'b1;
               end
               3'b010:  d_ctrl = FN_SLT;
               3'b110:  d_ctrl = FN_OR;
               3'b111:  d_ctrl = FN_AND;
               default: d_illegal = 1'b1;
            endcase
         end
         OP_LUI: begin
            d_ctrl = FN_PASSOP2;
            d_src  = 1'b1;
         end
         OP_BR: begin
            d_ctrl   = FN_SUB;
            d_branch = 1'b1;
            case (funct3)
               3'b000: d_bne = 1'b0;
`ifdef ALU_CTRL_BNE_EN
               3'b001: d_bne = 1'b1;
`endif
               default: d_illegal = 1'b1;
            endcase
         end
         default: d_illegal = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_q      <= '0;
         dec_ctrl_q   <= FN_ADD;
         dec_src_q    <= 1'b0;
         dec_branch_q <= 1'b0;
         dec_bne_q    <= 1'b0;
      end else begin
         if (state == S_IDLE && instr_valid_i) instr_q <= instr_i;
         if (state == S_DECODE) begin
            dec_ctrl_q   <= d_ctrl;
            dec_src_q    <= d_src;
            dec_branch_q <= d_branch;
            dec_bne_q    <= d_bne;
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   if (instr_valid_i) state_next = S_DECODE;
         S_DECODE: state_next = d_illegal ? S_ERR : S_EXEC;
         S_EXEC:   state_next = dec_branch_q ? S_BR : S_WB;
         S_WB,
         S_BR,
         S_ERR:    state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   always_comb begin
      instr_ready_o = 1'b0;
      alu_ctrl_o    = FN_ADD;
      alu_src_o     = 1'b0;
      reg_write_o   = 1'b0;
      pc_src_o      = 1'b0;
      illegal_o     = 1'b0;
      done_o        = 1'b0;
      case (state)
         S_IDLE: instr_ready_o = 1'b1;
         S_EXEC: begin
            alu_ctrl_o = dec_ctrl_q;
            alu_src_o  = dec_src_q;
         end
         S_WB: begin
            alu_ctrl_o  = dec_ctrl_q;
            alu_src_o   = dec_src_q;
            reg_write_o = 1'b1;
            done_o      = 1'b1;
         end
         S_BR: begin
            alu_ctrl_o = dec_ctrl_q;
            alu_src_o  = dec_src_q;
            pc_src_o   = dec_bne_q ? ~zero_i : zero_i;
            done_o     = 1'b1;
         end
         S_ERR: begin
            illegal_o = 1'b1;
            done_o    = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
module tb_alu_ctrl_fsm;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr_i;
   logic        instr_valid_i;
   logic        instr_ready_o;
   logic        zero_i;
   logic [2:0]  alu_ctrl_o;
   logic        alu_src_o;
   logic        reg_write_o;
   logic        pc_src_o;
   logic        illegal_o;
   logic        done_o;

   int n_checks = 0;
   int n_fail   = 0;

   alu_ctrl_fsm #(.DATA_WIDTH(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .instr_i       (instr_i),
      .instr_valid_i (instr_valid_i),
      .instr_ready_o (instr_ready_o),
      .zero_i        (zero_i),
      .alu_ctrl_o    (alu_ctrl_o),
      .alu_src_o     (alu_src_o),
      .reg_write_o   (reg_write_o),
      .pc_src_o      (pc_src_o),
      .illegal_o     (illegal_o),
      .done_o        (done_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: kind 0 = register write, 1 = branch, 2 = illegal.
   function automatic void model(input logic [31:0] w, output logic [2:0] c,
                                 output logic s, output int kind, output logic bne);
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      logic [2:0] fn_of_f3 [8];
      logic [7:0] f3_ok;
      op = w[6:0];
      f3 = w[14:12];
      f7 = w[31:25];
      fn_of_f3 = '{3'd0, 3'd5, 3'd4, 3'd0, 3'd0, 3'd0, 3'd3, 3'd2};
      f3_ok = 8'b1100_0111;
      c = 3'd0; s = 1'b0; kind = 2; bne = 1'b0;
      if ((op == 7'h33 || op == 7'h13) && f3_ok[f3]) begin
         kind = 0;
         c = fn_of_f3[f3];
         s = (op == 7'h13);
         if (op == 7'h33 && f3 == 3'd0) begin
            if (f7 == 7'h20)      c = 3'd1;
            else if (f7 != 7'h00) kind = 2;
         end
         if (op == 7'h13 && f3 == 3'd1 && f7 != 7'h00) kind = 2;
      end else if (op == 7'h37) begin
         kind = 0; c = 3'd6; s = 1'b1;
      end else if (op == 7'h63) begin
         c = 3'd1;
         if (f3 == 3'd0) kind = 1;
`ifdef ALU_CTRL_BNE_EN
         if (f3 == 3'd1) begin kind = 1; bne = 1'b1; end
`endif
      end
   endfunction

   // Issue one instruction and check every cycle of its lifetime. With hold set,
   // instr_valid_i stays high carrying nxt while the block is busy.
   task automatic run(input logic [31:0] w, input logic z, input logic hold, input logic [31:0] nxt);
      logic [2:0] c;
      logic       s;
      int         kind;
      logic       bne;
      int         k;
      model(w, c, s, kind, bne);
      k = 0;
      while (instr_ready_o !== 1'b1 && k < 8) begin
         @(posedge clk); #1;
         k++;
      end
      check("ready_before_accept", {31'd0, instr_ready_o}, 32'd1);
      instr_i = w;
      instr_valid_i = 1'b1;
      zero_i = 1'($urandom);
      @(posedge clk); #1;
      if (hold) instr_i = nxt;
      else begin
         instr_valid_i = 1'b0;
         instr_i = $urandom;
      end
      // DECODE
      check("dec_ready", {31'd0, instr_ready_o}, 32'd0);
      check("dec_ctrl", {29'd0, alu_ctrl_o}, 32'd0);
      check("dec_src", {31'd0, alu_src_o}, 32'd0);
      check("dec_done", {31'd0, done_o}, 32'd0);
      @(posedge clk); #1;
      if (kind == 2) begin
         check("err_illegal", {31'd0, illegal_o}, 32'd1);
         check("err_done", {31'd0, done_o}, 32'd1);
         check("err_wr", {31'd0, reg_write_o}, 32'd0);
         check("err_pc", {31'd0, pc_src_o}, 32'd0);
         @(posedge clk); #1;
         check("err_ready_after", {31'd0, instr_ready_o}, 32'd1);
         check("err_illegal_after", {31'd0, illegal_o}, 32'd0);
      end else begin
         check("exec_ctrl", {29'd0, alu_ctrl_o}, {29'd0, c});
         check("exec_src", {31'd0, alu_src_o}, {31'd0, s});
         check("exec_strobes", {28'd0, reg_write_o, pc_src_o, illegal_o, done_o}, 32'd0);
         zero_i = z;
         @(posedge clk); #1;
         check("last_ctrl", {29'd0, alu_ctrl_o}, {29'd0, c});
         check("last_src", {31'd0, alu_src_o}, {31'd0, s});
         check("last_wr", {31'd0, reg_write_o}, {31'd0, kind == 0});
         check("last_pc", {31'd0, pc_src_o}, {31'd0, kind == 1 && (bne ? !z : z)});
         check("last_done", {31'd0, done_o}, 32'd1);
         check("last_illegal", {31'd0, illegal_o}, 32'd0);
         @(posedge clk); #1;
         check("ready_after", {31'd0, instr_ready_o}, 32'd1);
         check("done_after", {31'd0, done_o}, 32'd0);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check(tag, {24'd0, instr_ready_o, alu_ctrl_o, alu_src_o, reg_write_o, pc_src_o, illegal_o, done_o},
            {24'd0, 1'b1, 3'd0, 5'd0});
   endtask

   initial begin
      logic [31:0] w;
      int          sel;
      rst = 1'b1;
      instr_i = '0;
      instr_valid_i = 1'b0;
      zero_i = 1'b0;
      #12;
      check_reset_outputs("reset_held");
      @(posedge clk); #1;
      rst = 1'b0;
      check_reset_outputs("reset_released");

      run(32'h002081B3, 1'b0, 1'b0, 32'h0);           // add
      run(32'h402081B3, 1'b0, 1'b1, 32'h0050E193);    // sub, ori held on valid
      run(32'h0050E193, 1'b0, 1'b0, 32'h0);           // ori
      run(32'h00208463, 1'b1, 1'b0, 32'h0);           // beq taken
      run(32'h00208463, 1'b0, 1'b0, 32'h0);           // beq not taken
      run(32'h00209463, 1'b0, 1'b0, 32'h0);           // bne
      run(32'h00209463, 1'b1, 1'b0, 32'h0);           // bne, zero set
      run(32'h123452B7, 1'b0, 1'b0, 32'h0);           // lui
      run(32'h00000000, 1'b0, 1'b1, 32'h002081B3);    // illegal, add held
      run(32'h002081B3, 1'b0, 1'b0, 32'h0);
      run(32'h022081B3, 1'b0, 1'b0, 32'h0);           // R funct3 000, bad funct7
      run(32'h02009093, 1'b0, 1'b0, 32'h0);           // slli, bad funct7

      // Reset during EXEC of an add while a sub is held on valid.
      instr_i = 32'h002081B3;
      instr_valid_i = 1'b1;
      @(posedge clk); #1;
      instr_i = 32'h402081B3;
      @(posedge clk); #1;
      check("pre_rst_exec_ctrl", {29'd0, alu_ctrl_o}, 32'd0);
      #2 rst = 1'b1;
      #1 check_reset_outputs("rst_async");
      @(posedge clk); #1;
      check_reset_outputs("rst_cycle1");
      @(posedge clk); #1;
      check_reset_outputs("rst_cycle2");
      rst = 1'b0;
      run(32'h402081B3, 1'b0, 1'b0, 32'h0);

      for (int i = 0; i < 60; i++) begin
         w = $urandom;
         sel = int'($urandom_range(0, 4));
         case (sel)
            0: w[6:0] = 7'h33;
            1: w[6:0] = 7'h13;
            2: w[6:0] = 7'h37;
            3: w[6:0] = 7'h63;
            default: ;
         endcase
         if ($urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
         if (sel == 3) w[14:12] = 3'($urandom_range(0, 2));
         run(w, 1'($urandom), 1'b0, 32'h0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
